mem_ctrl: RTL and testbench

//  Responder side of the instruction-fetch and data-access request protocols. It serves
//  IF/i-cache fetch misses and MEM-stage loads/stores, and serialises each onto the

---
 rtl/mem_ctrl_pkg.sv | 27 ++
 rtl/mem_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mem_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE    = 2'd0,
    MEM_INST_RD = 2'd1,
    MEM_DATA_RD = 2'd2,
    MEM_DATA_WR = 2'd3
  } mem_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [2:0] INST_BYTES = 3'd4;

  // Number of RAM beats for a data access; the unused code 11 is a word.
  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      SIZE_WORD: return 3'd4;
      default:   return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Serialises instruction fetches and data loads/stores onto a byte-wide
// synchronous RAM, one transaction at a time, with registered rdy pulses.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_needed_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  input  logic              inst_discard_i,
  output logic [DATA_W-1:0] inst_data_o,
  output logic              inst_rdy_o,
  output logic              inst_busy_o,
  input  logic              data_needed_i,
  input  logic              data_we_i,
  input  logic [1:0]        data_size_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  output logic [DATA_W-1:0] data_rdata_o,
  output logic              data_rdy_o,
  output logic              data_busy_o,
  input  logic [7:0]        mem_din_i,
  output logic [7:0]        mem_dout_o,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic              mem_wr_o
);

  mem_state_e        state, state_nxt;
  logic [2:0]        cnt, cnt_nxt;
  logic [2:0]        len, len_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [DATA_W-1:0] wdata_q, wdata_nxt;
  logic [DATA_W-1:0] asm_q, asm_nxt;
  logic [DATA_W-1:0] asm_ins;
  logic [1:0]        byte_idx;
  logic [DATA_W-1:0] inst_data_nxt, data_rdata_nxt;
  logic              inst_rdy_nxt, data_rdy_nxt;
  logic [7:0]        mem_dout_nxt;
  logic [ADDR_W-1:0] mem_a_nxt;
  logic              mem_wr_nxt;

  // Both requesters see the same occupancy flag; it is already low in the rdy cycle.
  assign inst_busy_o = (state != MEM_IDLE);
  assign data_busy_o = (state != MEM_IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= MEM_IDLE;
    else      state <= state_nxt;
  end

  // Next state and next values of every registered output.
  // cnt holds (edge index - 1): beats are issued while cnt < len, the byte read
  // for beat j is on mem_din_i when cnt == j+2, and a read finishes at cnt == len+1.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt + 3'd1;
    len_nxt        = len;
    addr_nxt       = addr_q;
    wdata_nxt      = wdata_q;
    asm_nxt        = asm_q;
    inst_data_nxt  = inst_data_o;
    data_rdata_nxt = data_rdata_o;
    inst_rdy_nxt   = 1'b0;
    data_rdy_nxt   = 1'b0;
    mem_dout_nxt   = 8'h00;
    mem_a_nxt      = '0;
    mem_wr_nxt     = 1'b0;
    byte_idx       = cnt[1:0] - 2'd2;
    asm_ins        = asm_q;
    asm_ins[{byte_idx, 3'b000} +: 8] = mem_din_i;

    case (state)
      MEM_IDLE: begin
        cnt_nxt = 3'd0;
        if (data_needed_i) begin
          state_nxt = data_we_i ? MEM_DATA_WR : MEM_DATA_RD;
          len_nxt   = size_to_bytes(data_size_i);
          addr_nxt  = data_addr_i;
          wdata_nxt = data_wdata_i;
          asm_nxt   = '0;
        end else if (inst_needed_i) begin
          state_nxt = MEM_INST_RD;
          len_nxt   = INST_BYTES;
          addr_nxt  = inst_addr_i;
          asm_nxt   = '0;
        end
      end

      MEM_INST_RD, MEM_DATA_RD: begin
        if (state == MEM_INST_RD && inst_discard_i) begin
          // Redirect: drop the fetch, any byte still in flight is never captured.
          state_nxt = MEM_IDLE;
        end else begin
          if (cnt < len) begin
            mem_a_nxt = addr_q;
            addr_nxt  = addr_q + 1'b1;
          end
          if (cnt >= 3'd2) asm_nxt = asm_ins;
          if (cnt == len + 3'd1) begin
            state_nxt = MEM_IDLE;
            if (state == MEM_INST_RD) begin
              inst_data_nxt = asm_ins;
              inst_rdy_nxt  = 1'b1;
            end else begin
              data_rdata_nxt = asm_ins;
              data_rdy_nxt   = 1'b1;
            end
          end
        end
      end

      MEM_DATA_WR: begin
        if (cnt < len) begin
          mem_wr_nxt   = 1'b1;
          mem_a_nxt    = addr_q;
          mem_dout_nxt = wdata_q[7:0];
          addr_nxt     = addr_q + 1'b1;
          wdata_nxt    = wdata_q >> 8;
        end else begin
          state_nxt    = MEM_IDLE;
          data_rdy_nxt = 1'b1;
        end
      end

      default: state_nxt = MEM_IDLE;
    endcase
  end

  // Counters, latched request and registered outputs; reset clears them all at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt          <= '0;
      len          <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      asm_q        <= '0;
      inst_data_o  <= '0;
      data_rdata_o <= '0;
      inst_rdy_o   <= 1'b0;
      data_rdy_o   <= 1'b0;
      mem_dout_o   <= '0;
      mem_a_o      <= '0;
      mem_wr_o     <= 1'b0;
    end else begin
      cnt          <= cnt_nxt;
      len          <= len_nxt;
      addr_q       <= addr_nxt;
      wdata_q      <= wdata_nxt;
      asm_q        <= asm_nxt;
      inst_data_o  <= inst_data_nxt;
      data_rdata_o <= data_rdata_nxt;
      inst_rdy_o   <= inst_rdy_nxt;
      data_rdy_o   <= data_rdy_nxt;
      mem_dout_o   <= mem_dout_nxt;
      mem_a_o      <= mem_a_nxt;
      mem_wr_o     <= mem_wr_nxt;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a small byte RAM model.
module tb_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        inst_needed_i;
  logic [31:0] inst_addr_i;
  logic        inst_discard_i;
  logic [31:0] inst_data_o;
  logic        inst_rdy_o;
  logic        inst_busy_o;
  logic        data_needed_i;
  logic        data_we_i;
  logic [1:0]  data_size_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [31:0] data_rdata_o;
  logic        data_rdy_o;
  logic        data_busy_o;
  logic [7:0]  mem_din_i;
  logic [7:0]  mem_dout_o;
  logic [31:0] mem_a_o;
  logic        mem_wr_o;

  logic [7:0]  ram [0:65535];
  logic        pl_en;
  logic [15:0] pl_addr;
  logic [7:0]  pl_data;

  int errors = 0;
  int checks = 0;

  mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .inst_needed_i(inst_needed_i), .inst_addr_i(inst_addr_i),
    .inst_discard_i(inst_discard_i), .inst_data_o(inst_data_o),
    .inst_rdy_o(inst_rdy_o), .inst_busy_o(inst_busy_o),
    .data_needed_i(data_needed_i), .data_we_i(data_we_i),
    .data_size_i(data_size_i), .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o),
    .data_rdy_o(data_rdy_o), .data_busy_o(data_busy_o),
    .mem_din_i(mem_din_i), .mem_dout_o(mem_dout_o),
    .mem_a_o(mem_a_o), .mem_wr_o(mem_wr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: read data one cycle after the address, writes on the strobe.
  always @(posedge clk) begin
    mem_din_i <= ram[mem_a_o[15:0]];
    if (mem_wr_o) ram[mem_a_o[15:0]] <= mem_dout_o;
    if (pl_en) ram[pl_addr] <= pl_data;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pl(input logic [15:0] a, input logic [7:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    tick();
    pl_en   = 1'b0;
  endtask

  // Presents a fetch at the next edge (edge 0); returns inside cycle 0.
  task automatic req_inst(input logic [31:0] a);
    inst_addr_i   = a;
    inst_needed_i = 1'b1;
    tick();
    inst_needed_i = 1'b0;
  endtask

  task automatic req_data(input logic we, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd);
    data_we_i     = we;
    data_size_i   = sz;
    data_addr_i   = a;
    data_wdata_i  = wd;
    data_needed_i = 1'b1;
    tick();
    data_needed_i = 1'b0;
  endtask

  // Full fetch: busy in cycles 0..5, addresses in cycles 1..4, rdy in cycle 6.
  task automatic run_fetch(input logic [31:0] a, input logic [31:0] exp);
    req_inst(a);
    chk("fetch_busy_c0", {31'd0, inst_busy_o}, 32'd1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("fetch_busy", {31'd0, inst_busy_o}, 32'd1);
      chk("fetch_rdy_early", {31'd0, inst_rdy_o}, 32'd0);
      if (k <= 4) chk("fetch_addr", mem_a_o, a + k - 1);
      else        chk("fetch_addr_idle", mem_a_o, 32'd0);
    end
    tick();
    chk("fetch_rdy", {31'd0, inst_rdy_o}, 32'd1);
    chk("fetch_data", inst_data_o, exp);
    chk("fetch_busy_rdy", {31'd0, inst_busy_o}, 32'd0);
    tick();
    chk("fetch_rdy_pulse", {31'd0, inst_rdy_o}, 32'd0);
    chk("fetch_data_hold", inst_data_o, exp);
  endtask

  // Fetch aborted by a discard raised during cycle c.
  task automatic run_discard(input logic [31:0] a, input int c, input logic [31:0] held);
    req_inst(a);
    for (int k = 1; k <= c; k++) tick();
    inst_discard_i = 1'b1;
    tick();
    inst_discard_i = 1'b0;
    chk("disc_idle", {31'd0, inst_busy_o}, 32'd0);
    chk("disc_addr", mem_a_o, 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("disc_no_rdy", {31'd0, inst_rdy_o}, 32'd0);
      tick();
    end
    chk("disc_data_held", inst_data_o, held);
  endtask

  logic [7:0] wr_bytes [4];

  initial begin
    rst = 1'b0;
    inst_needed_i = 1'b0; inst_addr_i = '0; inst_discard_i = 1'b0;
    data_needed_i = 1'b0; data_we_i = 1'b0; data_size_i = 2'b00;
    data_addr_i = '0; data_wdata_i = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;

    // RAM contents used by the directed cases.
    pl(16'h1000, 8'h13); pl(16'h1001, 8'h05); pl(16'h1002, 8'h00); pl(16'h1003, 8'h00);
    pl(16'h2000, 8'h93); pl(16'h2001, 8'h00); pl(16'h2002, 8'h10); pl(16'h2003, 8'h00);
    pl(16'h3000, 8'h37); pl(16'h3001, 8'h41); pl(16'h3002, 8'h00); pl(16'h3003, 8'h00);
    pl(16'h0033, 8'h80);
    pl(16'h0040, 8'h34); pl(16'h0041, 8'hA2);
    pl(16'h0050, 8'hA5); pl(16'h0051, 8'hA5); pl(16'h0052, 8'hA5); pl(16'h0053, 8'hA5);

    chk("rst_busy", {31'd0, inst_busy_o | data_busy_o}, 32'd0);
    chk("rst_rdy", {30'd0, inst_rdy_o, data_rdy_o}, 32'd0);
    chk("rst_wr", {31'd0, mem_wr_o}, 32'd0);
    chk("rst_addr", mem_a_o, 32'd0);
    chk("rst_rdata", data_rdata_o, 32'd0);
    rst = 1'b1;
    tick();

    // 1: fetch 0x1000 -> 0x00000513
    run_fetch(32'h1000, 32'h0000_0513);

    // 2: word store 0xDEADBEEF @0x20
    wr_bytes[0] = 8'hEF; wr_bytes[1] = 8'hBE; wr_bytes[2] = 8'hAD; wr_bytes[3] = 8'hDE;
    req_data(1'b1, 2'b10, 32'h20, 32'hDEAD_BEEF);
    chk("st_busy_c0", {31'd0, data_busy_o}, 32'd1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("st_wr", {31'd0, mem_wr_o}, 32'd1);
      chk("st_addr", mem_a_o, 32'h20 + k - 1);
      chk("st_byte", {24'd0, mem_dout_o}, {24'd0, wr_bytes[k-1]});
      chk("st_rdy_early", {31'd0, data_rdy_o}, 32'd0);
    end
    tick();
    chk("st_rdy", {31'd0, data_rdy_o}, 32'd1);
    chk("st_wr_off", {31'd0, mem_wr_o}, 32'd0);
    chk("st_addr_off", mem_a_o, 32'd0);
    chk("st_dout_off", {24'd0, mem_dout_o}, 32'd0);
    chk("st_busy_rdy", {31'd0, data_busy_o}, 32'd0);
    tick();

    // Size code 11 reads back the stored word.
    req_data(1'b0, 2'b11, 32'h20, 32'h0);
    for (int k = 1; k <= 6; k++) tick();
    chk("ld11_rdy", {31'd0, data_rdy_o}, 32'd1);
    chk("ld11_data", data_rdata_o, 32'hDEAD_BEEF);
    tick();

    // 3: byte load @0x33 -> 0x80 zero-extended, rdy in cycle 3
    req_data(1'b0, 2'b00, 32'h33, 32'h0);
    tick();
    chk("ldb_addr", mem_a_o, 32'h33);
    tick();
    chk("ldb_addr_idle", mem_a_o, 32'd0);
    chk("ldb_rdy_early", {31'd0, data_rdy_o}, 32'd0);
    tick();
    chk("ldb_rdy", {31'd0, data_rdy_o}, 32'd1);
    chk("ldb_data", data_rdata_o, 32'h0000_0080);
    tick();
    chk("ldb_hold", data_rdata_o, 32'h0000_0080);

    // 4: simultaneous requests; the half load wins, the fetch follows
    inst_addr_i = 32'h3000; inst_needed_i = 1'b1;
    data_we_i = 1'b0; data_size_i = 2'b01; data_addr_i = 32'h40; data_needed_i = 1'b1;
    tick();
    inst_needed_i = 1'b0; data_needed_i = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("arb_no_rdy", {30'd0, inst_rdy_o, data_rdy_o}, 32'd0);
    end
    tick();
    chk("arb_data_rdy", {31'd0, data_rdy_o}, 32'd1);
    chk("arb_inst_rdy", {31'd0, inst_rdy_o}, 32'd0);
    chk("arb_half", data_rdata_o, 32'h0000_A234);
    chk("arb_busy", {31'd0, data_busy_o}, 32'd0);
    run_fetch(32'h3000, 32'h0000_4137);

    // 5: discard in cycle 3, then a clean fetch; then discard in the final capture cycle
    run_discard(32'h1000, 3, 32'h0000_4137);
    run_fetch(32'h2000, 32'h0010_0093);
    run_discard(32'h1000, 5, 32'h0010_0093);

    // 6: reset in cycle 2 of a word store
    req_data(1'b1, 2'b10, 32'h50, 32'h1122_3344);
    tick();
    tick();
    chk("rs_wr_before", {31'd0, mem_wr_o}, 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("rs_wr", {31'd0, mem_wr_o}, 32'd0);
    chk("rs_addr", mem_a_o, 32'd0);
    chk("rs_dout", {24'd0, mem_dout_o}, 32'd0);
    chk("rs_busy", {31'd0, data_busy_o | inst_busy_o}, 32'd0);
    chk("rs_rdata", data_rdata_o | inst_data_o, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rs_no_rdy", {30'd0, data_rdy_o, mem_wr_o}, 32'd0);
    end
    chk("rs_ram50", {24'd0, ram[16'h0050]}, 32'h44);
    chk("rs_ram51", {24'd0, ram[16'h0051]}, 32'hA5);
    chk("rs_ram52", {24'd0, ram[16'h0052]}, 32'hA5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
